// File: rtl/av_master_arbiter_pkg.sv
// Shared types for the two-requester Avalon-MM master arbiter.
// The optional stall timeout is enabled by AV_MASTER_ARBITER_TIMEOUT_EN.
package av_master_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_MCU = 2'd1,
    ST_GNT_DBG = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_MCU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_e;

  // Read data returned to a requester whose transaction was aborted.
  localparam logic [15:0] ABORT_RDATA = 16'hDEAD;

  typedef struct packed {
    logic [15:0] address;
    logic [15:0] writedata;
    logic        write;
    logic        read;
  } av_req_t;

  function automatic logic is_request(input av_req_t r);
    return r.write | r.read;
  endfunction

endpackage

// File: rtl/av_arb_timeout.sv
// Stall counter for a granted transaction; only built when
// AV_MASTER_ARBITER_TIMEOUT_EN is defined.
`ifdef AV_MASTER_ARBITER_TIMEOUT_EN
module av_arb_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active_i,
  input  logic stall_i,
  output logic expired_o
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;

  assign expired_o = active_i && stall_i && (cnt_q == LIMIT);

  // Outside a grant the counter sits at zero, so every grant starts fresh.
  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = '0;
    if (active_i && stall_i && !expired_o) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignment for state so all flops update together.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule
`endif

// File: rtl/av_master_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master between MCU and debug.
// Define AV_MASTER_ARBITER_TIMEOUT_EN to abort grants stalled too long.
module av_master_arbiter
  import av_master_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        sysclk,
  input  logic        sysreset_n,
  input  logic [15:0] mcu_address,
  input  logic [15:0] mcu_writedata,
  input  logic        mcu_write,
  input  logic        mcu_read,
  output logic [15:0] mcu_readdata,
  output logic        mcu_waitrequest,
  input  logic [15:0] dbg_address,
  input  logic [15:0] dbg_writedata,
  input  logic        dbg_write,
  input  logic        dbg_read,
  output logic [15:0] dbg_readdata,
  output logic        dbg_waitrequest,
  output logic [15:0] m_address,
  output logic [15:0] m_writedata,
  output logic        m_write,
  output logic        m_read,
  input  logic [15:0] m_readdata,
  input  logic        m_waitrequest,
  output logic        grant_dbg,
  output logic        timeout_err,
  input  logic        err_clr
);

  arb_state_e state_q, state_d;
  req_id_e    last_grant_q, last_grant_d;
  av_req_t    mcu_req, dbg_req, sel_req;
  req_id_e    sel_id;
  logic       expired;
  logic       abort;
  logic       sel_wait;
  logic [15:0] sel_rdata;

  assign mcu_req = '{address: mcu_address, writedata: mcu_writedata,
                     write: mcu_write, read: mcu_read};
  assign dbg_req = '{address: dbg_address, writedata: dbg_writedata,
                     write: dbg_write, read: dbg_read};

  assign sel_id  = (state_q == ST_GNT_DBG) ? REQ_DBG : REQ_MCU;
  assign sel_req = (state_q == ST_GNT_DBG) ? dbg_req : mcu_req;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    abort        = 1'b0;
    m_address    = '0;
    m_writedata  = '0;
    m_write      = 1'b0;
    m_read       = 1'b0;
    sel_wait     = 1'b1;
    sel_rdata    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (is_request(mcu_req) && is_request(dbg_req))
          state_d = (last_grant_q == REQ_DBG) ? ST_GNT_MCU : ST_GNT_DBG;
        else if (is_request(mcu_req))
          state_d = ST_GNT_MCU;
        else if (is_request(dbg_req))
          state_d = ST_GNT_DBG;
      end
      ST_GNT_MCU, ST_GNT_DBG: begin
        // Simultaneous write and read is treated as a write.
        m_address   = sel_req.address;
        m_writedata = sel_req.writedata;
        m_write     = sel_req.write;
        m_read      = sel_req.read & ~sel_req.write;
        sel_wait    = m_waitrequest;
        sel_rdata   = m_readdata;
        if (!m_waitrequest) begin
          state_d      = ST_IDLE;
          last_grant_d = sel_id;
        end else if (!is_request(sel_req)) begin
          state_d = ST_IDLE;
        end else if (expired) begin
          abort     = 1'b1;
          m_write   = 1'b0;
          m_read    = 1'b0;
          sel_wait  = 1'b0;
          sel_rdata = ABORT_RDATA;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mcu_waitrequest = (state_q == ST_GNT_MCU) ? sel_wait  : 1'b1;
  assign dbg_waitrequest = (state_q == ST_GNT_DBG) ? sel_wait  : 1'b1;
  assign mcu_readdata    = (state_q == ST_GNT_MCU) ? sel_rdata : 16'h0000;
  assign dbg_readdata    = (state_q == ST_GNT_DBG) ? sel_rdata : 16'h0000;
  assign grant_dbg       = (state_q == ST_GNT_DBG);

  // Last grant resets to debug so the MCU wins the first tie.
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= REQ_DBG;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef AV_MASTER_ARBITER_TIMEOUT_EN
  logic err_q, err_d;

  av_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (sysclk),
    .rst_n     (sysreset_n),
    .active_i  (state_q != ST_IDLE),
    .stall_i   (m_waitrequest),
    .expired_o (expired)
  );

  // A fresh abort outranks a clear arriving in the same cycle.
  assign err_d = abort ? 1'b1 : (err_clr ? 1'b0 : err_q);

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) err_q <= 1'b0;
    else             err_q <= err_d;
  end

  assign timeout_err = err_q;
`else
  logic [1:0] unused_cfg;

  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_cfg  = {err_clr, TIMEOUT_CYCLES[0]};
`endif

endmodule

// File: tb/tb_av_master_arbiter.sv
// Self-checking bench for av_master_arbiter; adapts to
// AV_MASTER_ARBITER_TIMEOUT_EN for the timeout scenarios.
module tb_av_master_arbiter;

  localparam int T = 8;
`ifdef AV_MASTER_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        sysclk = 1'b0;
  logic        sysreset_n;
  logic [15:0] mcu_address, mcu_writedata, dbg_address, dbg_writedata;
  logic        mcu_write, mcu_read, dbg_write, dbg_read;
  logic [15:0] m_readdata;
  logic        m_waitrequest, err_clr;
  logic [15:0] mcu_readdata, dbg_readdata, m_address, m_writedata;
  logic        mcu_waitrequest, dbg_waitrequest, m_write, m_read;
  logic        grant_dbg, timeout_err;

  int checks = 0;
  int errors = 0;
  int mw_cnt = 0;
  int base;

  av_master_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .sysclk          (sysclk),
    .sysreset_n      (sysreset_n),
    .mcu_address     (mcu_address),
    .mcu_writedata   (mcu_writedata),
    .mcu_write       (mcu_write),
    .mcu_read        (mcu_read),
    .mcu_readdata    (mcu_readdata),
    .mcu_waitrequest (mcu_waitrequest),
    .dbg_address     (dbg_address),
    .dbg_writedata   (dbg_writedata),
    .dbg_write       (dbg_write),
    .dbg_read        (dbg_read),
    .dbg_readdata    (dbg_readdata),
    .dbg_waitrequest (dbg_waitrequest),
    .m_address       (m_address),
    .m_writedata     (m_writedata),
    .m_write         (m_write),
    .m_read          (m_read),
    .m_readdata      (m_readdata),
    .m_waitrequest   (m_waitrequest),
    .grant_dbg       (grant_dbg),
    .timeout_err     (timeout_err),
    .err_clr         (err_clr)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  // Transaction model: owner -1 = nobody, 0 = MCU, 1 = debug.
  int owner = -1, last_id = 1, age = 0;
  bit m_err = 1'b0;
  int nxt_owner = -1, nxt_last = 1, nxt_age = 0;
  bit nxt_err = 1'b0;

  always @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      owner <= -1; last_id <= 1; age <= 0; m_err <= 1'b0;
    end else begin
      owner <= nxt_owner; last_id <= nxt_last; age <= nxt_age; m_err <= nxt_err;
    end
  end

  always @(negedge sysclk) begin
    bit rq[2], wr[2], rd[2];
    logic [15:0] ad[2], wd[2], e_rdata[2];
    logic e_wait[2];
    logic [15:0] e_addr, e_wdata;
    logic e_wr, e_rd;
    int n_owner, n_last, n_age;
    bit n_err;

    wr[0] = mcu_write; rd[0] = mcu_read; ad[0] = mcu_address; wd[0] = mcu_writedata;
    wr[1] = dbg_write; rd[1] = dbg_read; ad[1] = dbg_address; wd[1] = dbg_writedata;
    rq[0] = wr[0] | rd[0];
    rq[1] = wr[1] | rd[1];
    e_addr = '0; e_wdata = '0; e_wr = 1'b0; e_rd = 1'b0;
    e_wait[0] = 1'b1; e_wait[1] = 1'b1; e_rdata[0] = '0; e_rdata[1] = '0;
    n_owner = owner; n_last = last_id; n_age = 0;
    n_err = TO_EN ? (m_err && !err_clr) : 1'b0;

    if (owner < 0) begin
      if (rq[0] && rq[1]) n_owner = 1 - last_id;
      else if (rq[0])     n_owner = 0;
      else if (rq[1])     n_owner = 1;
    end else begin
      e_addr = ad[owner]; e_wdata = wd[owner];
      e_wr = wr[owner]; e_rd = rd[owner] && !wr[owner];
      e_wait[owner] = m_waitrequest; e_rdata[owner] = m_readdata;
      if (!m_waitrequest) begin
        n_owner = -1; n_last = owner;
      end else if (!rq[owner]) begin
        n_owner = -1;
      end else if (TO_EN && age == T - 1) begin
        e_wr = 1'b0; e_rd = 1'b0;
        e_wait[owner] = 1'b0; e_rdata[owner] = 16'hDEAD;
        n_err = 1'b1; n_owner = -1;
      end else begin
        n_age = age + 1;
      end
    end

    check("m_address", m_address, e_addr);
    check("m_writedata", m_writedata, e_wdata);
    check("m_write", m_write, e_wr);
    check("m_read", m_read, e_rd);
    check("mcu_waitrequest", mcu_waitrequest, e_wait[0]);
    check("dbg_waitrequest", dbg_waitrequest, e_wait[1]);
    check("mcu_readdata", mcu_readdata, e_rdata[0]);
    check("dbg_readdata", dbg_readdata, e_rdata[1]);
    check("grant_dbg", grant_dbg, owner == 1);
    check("timeout_err", timeout_err, m_err);

    nxt_owner <= n_owner; nxt_last <= n_last; nxt_age <= n_age; nxt_err <= n_err;
    if (m_write) mw_cnt <= mw_cnt + 1;
  end

  initial begin
    sysreset_n = 1'b0;
    mcu_address = '0; mcu_writedata = '0; mcu_write = 1'b0; mcu_read = 1'b0;
    dbg_address = '0; dbg_writedata = '0; dbg_write = 1'b0; dbg_read = 1'b0;
    m_readdata = 16'h5A5A; m_waitrequest = 1'b1; err_clr = 1'b0;
    #12;
    check("rst m_write", m_write, 0);
    check("rst m_address", m_address, 0);
    check("rst mcu_wait", mcu_waitrequest, 1);
    check("rst dbg_wait", dbg_waitrequest, 1);
    check("rst grant_dbg", grant_dbg, 0);
    check("rst timeout_err", timeout_err, 0);
    @(posedge sysclk); #1 sysreset_n = 1'b1;

    // Ties after reset: MCU, then debug, then MCU again.
    mcu_read = 1'b1; mcu_address = 16'h0100;
    dbg_write = 1'b1; dbg_address = 16'h0200; dbg_writedata = 16'h00AA;
    m_waitrequest = 1'b0;
    tick();
    check("tie1 grant_dbg", grant_dbg, 0);
    check("tie1 mcu_wait", mcu_waitrequest, 0);
    check("tie1 dbg_wait", dbg_waitrequest, 1);
    check("tie1 m_address", m_address, 16'h0100);
    check("tie1 mcu_rdata", mcu_readdata, 16'h5A5A);
    tick();
    check("tie gap m_read", m_read, 0);
    check("tie gap m_write", m_write, 0);
    tick();
    check("tie2 grant_dbg", grant_dbg, 1);
    check("tie2 m_writedata", m_writedata, 16'h00AA);
    check("tie2 dbg_wait", dbg_waitrequest, 0);
    check("tie2 mcu_wait", mcu_waitrequest, 1);
    tick();
    tick();
    check("tie3 grant_dbg", grant_dbg, 0);
    check("tie3 mcu_wait", mcu_waitrequest, 0);
    tick();
    mcu_read = 1'b0; dbg_write = 1'b0; m_waitrequest = 1'b1;
    tick();

    // MCU write with three stall cycles, then a back-to-back write.
    mcu_write = 1'b1; mcu_address = 16'h0010; mcu_writedata = 16'h1234;
    base = mw_cnt;
    tick();
    check("wr m_write", m_write, 1);
    check("wr m_address", m_address, 16'h0010);
    check("wr m_writedata", m_writedata, 16'h1234);
    check("wr stall wait", mcu_waitrequest, 1);
    tick(); tick(); tick();
    m_waitrequest = 1'b0; #1;
    check("wr done wait", mcu_waitrequest, 0);
    tick();
    mcu_address = 16'h0012; mcu_writedata = 16'h5678; #1;
    check("wr m_write cycles", mw_cnt - base, 4);
    check("wr gap m_write", m_write, 0);
    check("wr gap mcu_wait", mcu_waitrequest, 1);
    tick();
    check("wr2 m_address", m_address, 16'h0012);
    check("wr2 mcu_wait", mcu_waitrequest, 0);
    tick();
    mcu_write = 1'b0; m_waitrequest = 1'b1;
    tick();

    // Debug read with zero wait.
    dbg_read = 1'b1; dbg_address = 16'h0004; m_readdata = 16'hBEEF; m_waitrequest = 1'b0;
    tick();
    check("rd dbg_readdata", dbg_readdata, 16'hBEEF);
    check("rd mcu_readdata", mcu_readdata, 16'h0000);
    check("rd m_read", m_read, 1);
    check("rd m_address", m_address, 16'h0004);
    check("rd grant_dbg", grant_dbg, 1);
    tick();
    dbg_read = 1'b0; m_readdata = 16'h5A5A; m_waitrequest = 1'b1; #1;
    check("rd idle dbg_readdata", dbg_readdata, 16'h0000);
    tick();

    // Write and read together count as a write.
    mcu_write = 1'b1; mcu_read = 1'b1; mcu_address = 16'h0020; m_waitrequest = 1'b0;
    tick();
    check("both m_write", m_write, 1);
    check("both m_read", m_read, 0);
    tick();
    mcu_write = 1'b0; mcu_read = 1'b0; m_waitrequest = 1'b1;
    tick();

    // Request withdrawn mid-grant.
    mcu_read = 1'b1; mcu_address = 16'h0030;
    tick();
    check("drop m_read before", m_read, 1);
    mcu_read = 1'b0; #1;
    check("drop m_read after", m_read, 0);
    check("drop mcu_wait", mcu_waitrequest, 1);
    tick();
    check("drop timeout_err", timeout_err, 0);
    tick();

    // Reset during a stalled grant.
    mcu_write = 1'b1; mcu_address = 16'h0040; mcu_writedata = 16'h9999;
    tick(); tick();
    check("rstmid m_write before", m_write, 1);
    #2 sysreset_n = 1'b0;
    #1;
    check("rstmid m_write", m_write, 0);
    check("rstmid m_address", m_address, 0);
    check("rstmid mcu_wait", mcu_waitrequest, 1);
    check("rstmid dbg_wait", dbg_waitrequest, 1);
    mcu_write = 1'b0;
    tick();
    sysreset_n = 1'b1;
    tick();

`ifdef AV_MASTER_ARBITER_TIMEOUT_EN
    // Slave stalls forever: abort on the eighth grant cycle.
    mcu_read = 1'b1; mcu_address = 16'h0050; m_readdata = 16'h1111;
    tick();
    for (int i = 1; i < T; i++) begin
      check("to stall wait", mcu_waitrequest, 1);
      tick();
    end
    check("to abort wait", mcu_waitrequest, 0);
    check("to abort rdata", mcu_readdata, 16'hDEAD);
    check("to abort m_read", m_read, 0);
    check("to err before", timeout_err, 0);
    tick();
    mcu_read = 1'b0; #1;
    check("to err set", timeout_err, 1);
    tick(); tick();
    check("to err sticky", timeout_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0; #1;
    check("to err cleared", timeout_err, 0);

    // A clear coinciding with a new abort loses.
    mcu_read = 1'b1;
    tick();
    for (int i = 1; i < T; i++) tick();
    err_clr = 1'b1; #1;
    check("to abort2 wait", mcu_waitrequest, 0);
    tick();
    err_clr = 1'b0; mcu_read = 1'b0; #1;
    check("to clr vs abort", timeout_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0; #1;
    check("to err cleared2", timeout_err, 0);
`else
    // Without the timeout a stalled grant is held indefinitely.
    mcu_read = 1'b1; mcu_address = 16'h0050; m_readdata = 16'h1111;
    err_clr = 1'b1;
    tick();
    for (int i = 0; i < 3 * T; i++) begin
      check("hold m_read", m_read, 1);
      check("hold mcu_wait", mcu_waitrequest, 1);
      check("hold timeout_err", timeout_err, 0);
      tick();
    end
    err_clr = 1'b0;
    m_waitrequest = 1'b0; #1;
    check("hold release wait", mcu_waitrequest, 0);
    check("hold release rdata", mcu_readdata, 16'h1111);
    tick();
    mcu_read = 1'b0; m_waitrequest = 1'b1;
`endif
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/av_master_arbiter.md
AV_MASTER_ARBITER -- requirements
Module: av_master_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, is the cycles a granted transaction may stall before it is aborted (valid range 2..65535).
REQ-002 sysclk  in  1  sole clock; all state updates on posedge.
REQ-003 sysreset_n  in  1  asynchronous, active-low reset.
REQ-004 mcu_address, mcu_writedata  in  16 each  MCU requester address and write data.
REQ-005 mcu_write, mcu_read  in  1 each  MCU requester strobes; both high at once is illegal and treated as write.
REQ-006 mcu_readdata  out  16, and mcu_waitrequest  out  1: MCU read return and stall.
REQ-007 dbg_address, dbg_writedata, dbg_write, dbg_read, dbg_readdata, dbg_waitrequest: debug-supervisor requester, same widths, directions and meaning as the mcu_* ports.
REQ-008 m_address, m_writedata  out  16 each  shared Avalon-MM master address and data.
REQ-009 m_write, m_read  out  1 each  shared master strobes.
REQ-010 m_readdata  in  16, and m_waitrequest  in  1: slave return and stall.
REQ-011 grant_dbg  out  1  high while the debug requester owns the master.
REQ-012 timeout_err  out  1  sticky abort flag; err_clr  in  1  clears it.

Function
REQ-013 The FSM SHALL have states IDLE, GNT_MCU and GNT_DBG.
REQ-014 IDLE: a lone request (write|read) SHALL go to that requester's GNT state on the next edge. If both request, the requester not granted last SHALL win (round-robin).
REQ-015 In GNT_x, m_* SHALL mirror requester x combinationally. In IDLE, m_write=m_read=0 and m_address=m_writedata=0.
REQ-016 Requester x waitrequest SHALL equal NOT(state==GNT_x AND m_waitrequest==0). A requester is never released outside its grant.
REQ-017 x_readdata SHALL equal m_readdata while in GNT_x, and 0 otherwise.
REQ-018 Completion is a cycle in GNT_x with m_waitrequest==0. The FSM SHALL then return to IDLE, so at least one idle cycle separates transactions, and last_grant SHALL update to x.
REQ-019 Minimum requester latency is 2 cycles: request seen in IDLE, grant, then completion on the first cycle with m_waitrequest low.
REQ-020 Requesters SHALL hold their signals stable while waitrequest is high. The arbiter does not latch them.
REQ-021 A request deasserted mid-grant (protocol violation) SHALL drop the master strobes and return to IDLE on the next edge, with no error flagged.
REQ-022 grant_dbg SHALL be 1 exactly in GNT_DBG.

Reset
REQ-023 Reset assertion SHALL immediately force IDLE, last_grant=DBG (so MCU wins the first tie), timeout_err=0, counter=0, m_write=m_read=0 and both waitrequests=1. A transaction in flight is abandoned.

Configuration
REQ-024 Macro AV_MASTER_ARBITER_TIMEOUT_EN.
- Defined: a 16-bit counter clears on entry to GNT and increments each stalled GNT cycle. When it reaches TIMEOUT_CYCLES-1 with m_waitrequest still high, the arbiter SHALL force m_write=m_read=0, drive x_waitrequest=0 and x_readdata=16'hDEAD for that one cycle, set timeout_err, and go to IDLE.
- Not defined: no counter, timeout_err tied 0, err_clr ignored, and a grant persists until completion.
REQ-025 err_clr SHALL clear timeout_err on the next edge. A simultaneous new timeout SHALL win (flag stays 1).

Structure
REQ-026 A shared package SHALL hold the FSM state enum (IDLE/GNT_MCU/GNT_DBG), the requester-id encoding and the 16'hDEAD abort constant.
REQ-027 One sub-module, av_arb_timeout (counter plus compare), is natural. It is instantiated only under the macro.

Verification
REQ-028 MCU write 0x0010<-0x1234 with slave waitrequest high 3 cycles -> m_write high 4 cycles, mcu_waitrequest low on the 4th, then one IDLE cycle.
REQ-029 MCU and dbg both request in IDLE after reset -> MCU granted first. On the next tie, dbg is granted.
REQ-030 dbg read of 0x0004, slave returns 0xBEEF with zero wait -> dbg_readdata=0xBEEF on the completion cycle and mcu_readdata=0.
REQ-031 Reset asserted mid-grant with m_waitrequest high -> m_write drops asynchronously, state is IDLE and both waitrequests are 1.
REQ-032 With the macro defined, TIMEOUT_CYCLES=8 and the slave stalled forever -> abort on the 8th GNT cycle, readdata 0xDEAD, timeout_err=1 until err_clr is pulsed.
REQ-033 With the macro undefined, the same stall -> grant held indefinitely and timeout_err stays 0.
